gray2rgb_frame_ctrl: RTL

- Frame sequencer for the grayscale-to-RGB output stage.
- On a start pulse it scans one IMG_W x IMG_H grayscale frame buffer in row-major order.
- It feeds each pixel into the grayscale_to_rgb converter (valid-qualified, fixed 1-cycle latency, no stall input).
- It collects converter results into a small skid FIFO and presents them as a ready/valid RGB stream with a last-pixel flag.
- Credit-based issue gives downstream backpressure without loss, although the converter itself cannot stall.

---
 rtl/gray2rgb_pkg.sv | 29 ++
 rtl/rgb_skid_fifo.sv | 72 +++++++
 rtl/gray2rgb_frame_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gray2rgb_pkg.sv
// -----------------------------------------------------------------------------
// gray2rgb_pkg
// Shared definitions for the grayscale-to-RGB frame sequencer:
//   - pixel / RGB widths and default frame geometry
//   - sequencer state encoding
//   - skid FIFO entry layout {last, rgb}
// -----------------------------------------------------------------------------
package gray2rgb_pkg;

    localparam int PIX_W     = 8;
    localparam int RGB_W     = 24;
    localparam int ENTRY_W   = RGB_W + 1;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             last;
        logic [RGB_W-1:0] rgb;
    } fifo_entry_t;

endpackage

// File: rtl/rgb_skid_fifo.sv
// -----------------------------------------------------------------------------
// rgb_skid_fifo
// Show-ahead FIFO that absorbs converter results while downstream stalls.
// The head entry is visible whenever valid_o is high; a read consumes it.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   wr_en_i      write strobe, wr_data_i entry to store
//   rd_en_i      consume the head entry (ignored when empty)
//   valid_o      FIFO holds at least one entry
//   head_o       oldest entry
//   count_o      current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module rgb_skid_fifo
    import gray2rgb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_wr;
    logic               do_rd;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);
    // A write into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_wr = wr_en_i && ((count_q != CNT_W'(DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gray2rgb_frame_ctrl.sv
// -----------------------------------------------------------------------------
// gray2rgb_frame_ctrl
// Scans one IMG_W x IMG_H grayscale frame in row-major order, feeds each pixel
// to an external 1-cycle grayscale_to_rgb converter and returns the results as
// a ready/valid RGB stream with a last-pixel flag. Reads are credit-limited so
// the non-stallable converter can never overrun the skid FIFO.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start_i                  frame start (sampled in IDLE only)
//   busy_o, frame_done_o     frame in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o       frame-buffer read request
//   rd_data_i                read data, one cycle after rd_en_o
//   conv_gray_o, conv_valid_o        to converter
//   conv_{red,green,blue}_i, conv_valid_i  from converter
//   pix_rgb_o, pix_valid_o, pix_ready_i, pix_last_o  RGB output stream
// -----------------------------------------------------------------------------
module gray2rgb_frame_ctrl
    import gray2rgb_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [PIX_W-1:0]  rd_data_i,
    output logic [PIX_W-1:0]  conv_gray_o,
    output logic              conv_valid_o,
    input  logic [PIX_W-1:0]  conv_red_i,
    input  logic [PIX_W-1:0]  conv_green_i,
    input  logic [PIX_W-1:0]  conv_blue_i,
    input  logic              conv_valid_i,
    output logic [RGB_W-1:0]  pix_rgb_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_last_o
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               vld_p1_q;
    logic               vld_p2_q;
    logic               last_p1_q;
    logic               last_p2_q;

    logic               credit_ok;
    logic               issue;
    logic               issue_last;
    logic               pop;
    logic               last_hs;

    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head_raw;
    fifo_entry_t        fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    // Reads issued in the two previous cycles are still in the memory/converter
    // path and will land in the FIFO regardless of downstream ready.
    assign credit_ok  = (32'(fifo_count) + 32'(vld_p1_q) + 32'(vld_p2_q)) < 32'(FIFO_DEPTH);
    assign issue      = (state_q == RUN) && credit_ok;
    assign issue_last = issue && (addr_q == LAST_ADDR);

    assign pop        = fifo_valid && pix_ready_i;
    assign last_hs    = pop && fifo_head.last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        // Address holds at the final pixel; no wrap.
                        if (issue_last) state_q <= DRAIN;
                        else            addr_q  <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stage p1: read data returns from the frame buffer.
    // Stage p2: converter result arrives; the last bit rides alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p1_q <= 1'b0;
            last_p2_q <= 1'b0;
        end else begin
            vld_p1_q  <= issue;
            vld_p2_q  <= vld_p1_q;
            last_p1_q <= issue_last;
            last_p2_q <= last_p1_q;
        end
    end

    rgb_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (conv_valid_i),
        .wr_data_i ({last_p2_q, conv_red_i, conv_green_i, conv_blue_i}),
        .rd_en_i   (pix_ready_i),
        .valid_o   (fifo_valid),
        .head_o    (fifo_head_raw),
        .count_o   (fifo_count)
    );

    assign fifo_head    = fifo_entry_t'(fifo_head_raw);

    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign rd_en_o      = issue;
    assign rd_addr_o    = addr_q;

    // Gray data is forced to 0 outside valid cycles so idle outputs stay quiet.
    assign conv_valid_o = vld_p1_q;
    assign conv_gray_o  = vld_p1_q ? rd_data_i : '0;

    assign pix_valid_o  = fifo_valid;
    assign pix_rgb_o    = fifo_valid ? fifo_head.rgb : '0;
    assign pix_last_o   = fifo_valid & fifo_head.last;

endmodule
